// File: rtl/mem_stage.sv
// RV32I memory-access stage with MEM/WB pipeline register.
// Drives a req/ack data bus, formats load data and stalls upstream while a transfer is pending.
module mem_stage #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        MEM_Valid,
    input  logic        MEM_RegWrite,
    input  logic [4:0]  MEM_RD,
    input  logic [1:0]  MEM_RegWriteSrc,
    input  logic        MEM_MemRead,
    input  logic        MEM_MemWrite,
    input  logic [2:0]  MEM_Funct3,
    input  logic [31:0] MEM_AluResult,
    input  logic [31:0] MEM_WriteData,
    input  logic [31:0] MEM_PCPlus4,
    output logic        MEM_Stall,
    output logic        MEM_Misaligned,
    output logic        MEM_BusError,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic        WB_RegWrite,
    output logic [4:0]  WB_RD,
    output logic [1:0]  WB_RegWriteSrc,
    output logic [31:0] WB_AluResult,
    output logic [31:0] WB_ReadData,
    output logic [31:0] WB_PCPlus4
);

    typedef enum logic {IDLE, REQ} state_t;

    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    state_t        state_reg, state_next;
    logic [CW-1:0] timeout_cnt_reg;
    logic          ld_load_reg;
    logic [2:0]    ld_funct3_reg;
    logic [1:0]    ld_lo_reg;

    logic        memop, funct3_legal, addr_misaligned, bad_access, timed_out;
    logic        start_req, wb_take;
    logic [3:0]  req_be;
    logic [31:0] req_wdata;
    logic [7:0]  lane_byte;
    logic [15:0] lane_half;
    logic [31:0] load_fmt;

    assign memop = MEM_Valid & (MEM_MemRead | MEM_MemWrite);
    assign funct3_legal = MEM_MemRead
        ? (MEM_Funct3 == 3'b000 || MEM_Funct3 == 3'b001 || MEM_Funct3 == 3'b010 ||
           MEM_Funct3 == 3'b100 || MEM_Funct3 == 3'b101)
        : (MEM_Funct3 == 3'b000 || MEM_Funct3 == 3'b001 || MEM_Funct3 == 3'b010);
    assign addr_misaligned = (MEM_Funct3[1:0] == 2'b01 && MEM_AluResult[0]) ||
                             (MEM_Funct3[1:0] == 2'b10 && MEM_AluResult[1:0] != 2'b00);
    assign bad_access = ~funct3_legal | addr_misaligned;
    assign timed_out  = (TIMEOUT_CYCLES > 0) && (int'(timeout_cnt_reg) == TIMEOUT_CYCLES - 1);

    // Per-lane byte enable and store data; halfwords replicate into both halves.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign req_be[gi] = MEM_MemRead ? 1'b1 :
                                (MEM_Funct3[1:0] == 2'b00) ? (MEM_AluResult[1:0] == 2'(gi)) :
                                (MEM_Funct3[1:0] == 2'b01) ? (MEM_AluResult[1] == (gi >= 2)) :
                                1'b1;
            assign req_wdata[8*gi +: 8] = MEM_MemRead ? 8'h00 :
                                (MEM_Funct3[1:0] == 2'b00) ? MEM_WriteData[7:0] :
                                (MEM_Funct3[1:0] == 2'b01) ? MEM_WriteData[8*(gi%2) +: 8] :
                                MEM_WriteData[8*gi +: 8];
        end
    endgenerate

    always_comb begin
        lane_byte = dmem_rdata[{ld_lo_reg, 3'b000} +: 8];
        lane_half = dmem_rdata[{ld_lo_reg[1], 4'b0000} +: 16];
        case (ld_funct3_reg)
            3'b000:  load_fmt = {{24{lane_byte[7]}}, lane_byte};
            3'b001:  load_fmt = {{16{lane_half[15]}}, lane_half};
            3'b100:  load_fmt = {24'h000000, lane_byte};
            3'b101:  load_fmt = {16'h0000, lane_half};
            default: load_fmt = dmem_rdata;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state_reg <= IDLE;
        else     state_reg <= state_next;
    end

    always_comb begin
        state_next     = state_reg;
        MEM_Stall      = 1'b0;
        MEM_Misaligned = 1'b0;
        MEM_BusError   = 1'b0;
        start_req      = 1'b0;
        wb_take        = 1'b0;
        case (state_reg)
            IDLE: begin
                if (memop) begin
                    if (bad_access) begin
                        MEM_Misaligned = ~rst;
                    end else begin
                        MEM_Stall  = 1'b1;
                        start_req  = 1'b1;
                        state_next = REQ;
                    end
                end else begin
                    wb_take = 1'b1;
                end
            end
            REQ: begin
                // A completing ack takes priority over an expiring timeout.
                if (dmem_ack) begin
                    wb_take    = 1'b1;
                    state_next = IDLE;
                end else if (timed_out) begin
                    MEM_BusError = ~rst;
                    state_next   = IDLE;
                end else begin
                    MEM_Stall = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dmem_req        <= 1'b0;
            dmem_we         <= 1'b0;
            dmem_addr       <= 32'h0;
            dmem_be         <= 4'h0;
            dmem_wdata      <= 32'h0;
            ld_load_reg     <= 1'b0;
            ld_funct3_reg   <= 3'b000;
            ld_lo_reg       <= 2'b00;
            timeout_cnt_reg <= '0;
        end else if (start_req) begin
            dmem_req        <= 1'b1;
            dmem_we         <= MEM_MemWrite & ~MEM_MemRead;
            dmem_addr       <= {MEM_AluResult[31:2], 2'b00};
            dmem_be         <= req_be;
            dmem_wdata      <= req_wdata;
            ld_load_reg     <= MEM_MemRead;
            ld_funct3_reg   <= MEM_Funct3;
            ld_lo_reg       <= MEM_AluResult[1:0];
            timeout_cnt_reg <= '0;
        end else if (state_reg == REQ) begin
            if (state_next == IDLE) dmem_req <= 1'b0;
            else                    timeout_cnt_reg <= timeout_cnt_reg + CW'(1);
        end
    end

    // Anything other than a completing instruction becomes a bubble.
    always_ff @(posedge clk) begin
        if (rst || !wb_take) begin
            WB_RegWrite    <= 1'b0;
            WB_RD          <= 5'd0;
            WB_RegWriteSrc <= 2'b00;
            WB_AluResult   <= 32'h0;
            WB_ReadData    <= 32'h0;
            WB_PCPlus4     <= 32'h0;
        end else begin
            WB_RegWrite    <= MEM_RegWrite & MEM_Valid;
            WB_RD          <= MEM_RD;
            WB_RegWriteSrc <= MEM_RegWriteSrc;
            WB_AluResult   <= MEM_AluResult;
            WB_ReadData    <= (state_reg == REQ && ld_load_reg) ? load_fmt : 32'h0;
            WB_PCPlus4     <= MEM_PCPlus4;
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage with a short bus timeout.
module tb_mem_stage;
    logic        clk = 1'b0;
    logic        rst;
    logic        MEM_Valid, MEM_RegWrite, MEM_MemRead, MEM_MemWrite;
    logic [4:0]  MEM_RD;
    logic [1:0]  MEM_RegWriteSrc;
    logic [2:0]  MEM_Funct3;
    logic [31:0] MEM_AluResult, MEM_WriteData, MEM_PCPlus4;
    logic        MEM_Stall, MEM_Misaligned, MEM_BusError;
    logic        dmem_req, dmem_we, dmem_ack;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic [3:0]  dmem_be;
    logic        WB_RegWrite;
    logic [4:0]  WB_RD;
    logic [1:0]  WB_RegWriteSrc;
    logic [31:0] WB_AluResult, WB_ReadData, WB_PCPlus4;

    int checks = 0;
    int errors = 0;
    int stall_cycles;
    int req_cycles;

    mem_stage #(.TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .rst(rst),
        .MEM_Valid(MEM_Valid), .MEM_RegWrite(MEM_RegWrite), .MEM_RD(MEM_RD),
        .MEM_RegWriteSrc(MEM_RegWriteSrc), .MEM_MemRead(MEM_MemRead),
        .MEM_MemWrite(MEM_MemWrite), .MEM_Funct3(MEM_Funct3),
        .MEM_AluResult(MEM_AluResult), .MEM_WriteData(MEM_WriteData),
        .MEM_PCPlus4(MEM_PCPlus4), .MEM_Stall(MEM_Stall),
        .MEM_Misaligned(MEM_Misaligned), .MEM_BusError(MEM_BusError),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_be(dmem_be), .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack),
        .dmem_rdata(dmem_rdata), .WB_RegWrite(WB_RegWrite), .WB_RD(WB_RD),
        .WB_RegWriteSrc(WB_RegWriteSrc), .WB_AluResult(WB_AluResult),
        .WB_ReadData(WB_ReadData), .WB_PCPlus4(WB_PCPlus4)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic set_op(input logic valid, input logic rw, input logic [4:0] rd,
                          input logic [1:0] src, input logic rd_op, input logic wr_op,
                          input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wd);
        MEM_Valid = valid; MEM_RegWrite = rw; MEM_RD = rd; MEM_RegWriteSrc = src;
        MEM_MemRead = rd_op; MEM_MemWrite = wr_op; MEM_Funct3 = f3;
        MEM_AluResult = addr; MEM_WriteData = wd; MEM_PCPlus4 = 32'h0000_0044;
    endtask

    initial begin
        rst = 1'b1; dmem_ack = 1'b0; dmem_rdata = 32'h0;
        set_op(1'b0, 1'b0, 5'd0, 2'b00, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        tick(); tick();
        check("reset_req", 32'(dmem_req), 32'd0);
        check("reset_wb_regwrite", 32'(WB_RegWrite), 32'd0);
        check("reset_wb_alu", WB_AluResult, 32'h0);
        check("reset_be", 32'(dmem_be), 32'h0);
        rst = 1'b0;

        // ALU op passes straight through
        set_op(1'b1, 1'b1, 5'd5, 2'b00, 1'b0, 1'b0, 3'b000, 32'h1234, 32'h0);
        settle();
        check("alu_stall", 32'(MEM_Stall), 32'd0);
        tick();
        check("alu_wb_regwrite", 32'(WB_RegWrite), 32'd1);
        check("alu_wb_rd", 32'(WB_RD), 32'd5);
        check("alu_wb_alu", WB_AluResult, 32'h1234);
        check("alu_wb_pc4", WB_PCPlus4, 32'h44);
        check("alu_wb_rdata", WB_ReadData, 32'h0);

        // Invalid slot never writes
        set_op(1'b0, 1'b1, 5'd6, 2'b10, 1'b0, 1'b0, 3'b000, 32'h99, 32'h0);
        tick();
        check("invalid_wb_regwrite", 32'(WB_RegWrite), 32'd0);

        // LB 0x103, ack three cycles after req rises
        set_op(1'b1, 1'b1, 5'd7, 2'b01, 1'b1, 1'b0, 3'b000, 32'h103, 32'h0);
        stall_cycles = 0;
        settle();
        if (MEM_Stall) stall_cycles++;
        tick();
        check("lb_req", 32'(dmem_req), 32'd1);
        check("lb_addr", dmem_addr, 32'h100);
        check("lb_be", 32'(dmem_be), 32'hF);
        check("lb_we", 32'(dmem_we), 32'd0);
        check("lb_wb_bubble", 32'(WB_RegWrite), 32'd0);
        if (MEM_Stall) stall_cycles++;
        tick(); if (MEM_Stall) stall_cycles++;
        tick(); if (MEM_Stall) stall_cycles++;
        tick();
        dmem_ack = 1'b1; dmem_rdata = 32'h80FF_0000;
        settle();
        if (MEM_Stall) stall_cycles++;
        check("lb_stall_cycles", 32'(stall_cycles), 32'd4);
        check("lb_ack_no_buserr", 32'(MEM_BusError), 32'd0);
        tick();
        dmem_ack = 1'b0;
        set_op(1'b0, 1'b0, 5'd0, 2'b00, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        check("lb_wb_regwrite", 32'(WB_RegWrite), 32'd1);
        check("lb_wb_rd", 32'(WB_RD), 32'd7);
        check("lb_wb_src", 32'(WB_RegWriteSrc), 32'd1);
        check("lb_wb_rdata", WB_ReadData, 32'hFFFF_FF80);
        check("lb_req_dropped", 32'(dmem_req), 32'd0);

        // LHU 0x106 with minimum latency
        set_op(1'b1, 1'b1, 5'd8, 2'b01, 1'b1, 1'b0, 3'b101, 32'h106, 32'h0);
        tick();
        dmem_ack = 1'b1; dmem_rdata = 32'h8001_1234;
        settle();
        check("lhu_stall_on_ack", 32'(MEM_Stall), 32'd0);
        tick();
        dmem_ack = 1'b0;
        set_op(1'b0, 1'b0, 5'd0, 2'b00, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        check("lhu_wb_rdata", WB_ReadData, 32'h0000_8001);

        // SH 0x202
        set_op(1'b1, 1'b0, 5'd0, 2'b00, 1'b0, 1'b1, 3'b001, 32'h202, 32'h0000_ABCD);
        tick();
        check("sh_addr", dmem_addr, 32'h200);
        check("sh_be", 32'(dmem_be), 32'hC);
        check("sh_wdata", dmem_wdata, 32'hABCD_ABCD);
        check("sh_we", 32'(dmem_we), 32'd1);
        dmem_ack = 1'b1;
        tick();
        dmem_ack = 1'b0;
        set_op(1'b0, 1'b0, 5'd0, 2'b00, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        check("sh_wb_rdata", WB_ReadData, 32'h0);

        // SB 0x301
        set_op(1'b1, 1'b0, 5'd0, 2'b00, 1'b0, 1'b1, 3'b000, 32'h301, 32'h0000_1255);
        tick();
        check("sb_be", 32'(dmem_be), 32'h2);
        check("sb_wdata", dmem_wdata, 32'h5555_5555);
        dmem_ack = 1'b1;
        tick();
        dmem_ack = 1'b0;

        // ALU op then misaligned LW 0x101
        set_op(1'b1, 1'b1, 5'd3, 2'b10, 1'b0, 1'b0, 3'b000, 32'h77, 32'h0);
        tick();
        check("pre_mis_wb_src", 32'(WB_RegWriteSrc), 32'd2);
        set_op(1'b1, 1'b1, 5'd9, 2'b01, 1'b1, 1'b0, 3'b010, 32'h101, 32'h0);
        settle();
        check("lw_mis_pulse", 32'(MEM_Misaligned), 32'd1);
        check("lw_mis_stall", 32'(MEM_Stall), 32'd0);
        tick();
        set_op(1'b0, 1'b0, 5'd0, 2'b00, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        settle();
        check("lw_mis_req", 32'(dmem_req), 32'd0);
        check("lw_mis_wb_bubble", 32'(WB_RegWrite), 32'd0);
        check("lw_mis_pulse_end", 32'(MEM_Misaligned), 32'd0);

        // Illegal store funct3
        set_op(1'b1, 1'b0, 5'd0, 2'b00, 1'b0, 1'b1, 3'b100, 32'h0, 32'h0);
        settle();
        check("illegal_f3", 32'(MEM_Misaligned), 32'd1);
        tick();
        set_op(1'b0, 1'b0, 5'd0, 2'b00, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);

        // Timeout with no ack
        set_op(1'b1, 1'b1, 5'd10, 2'b01, 1'b1, 1'b0, 3'b010, 32'h400, 32'h0);
        req_cycles = 0;
        tick();
        for (int i = 0; i < 3; i++) begin
            if (dmem_req) req_cycles++;
            check("to_no_err_early", 32'(MEM_BusError), 32'd0);
            tick();
        end
        if (dmem_req) req_cycles++;
        check("to_buserr", 32'(MEM_BusError), 32'd1);
        check("to_stall_released", 32'(MEM_Stall), 32'd0);
        check("to_req_cycles", 32'(req_cycles), 32'd4);
        tick();
        set_op(1'b0, 1'b0, 5'd0, 2'b00, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        settle();
        check("to_req_dropped", 32'(dmem_req), 32'd0);
        check("to_wb_bubble", 32'(WB_RegWrite), 32'd0);
        check("to_buserr_end", 32'(MEM_BusError), 32'd0);

        // Reset while waiting for ack
        set_op(1'b1, 1'b1, 5'd11, 2'b01, 1'b1, 1'b0, 3'b010, 32'h500, 32'h0);
        tick();
        tick();
        rst = 1'b1;
        tick();
        check("rst_mid_req", 32'(dmem_req), 32'd0);
        check("rst_mid_wb", 32'(WB_RegWrite), 32'd0);
        check("rst_mid_wb_alu", WB_AluResult, 32'h0);
        rst = 1'b0;
        set_op(1'b0, 1'b0, 5'd0, 2'b00, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        dmem_ack = 1'b1; dmem_rdata = 32'hDEAD_BEEF;
        tick();
        dmem_ack = 1'b0;
        check("late_ack_req", 32'(dmem_req), 32'd0);
        check("late_ack_wb_rdata", WB_ReadData, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
